// File: rtl/matrix_cursor_if.sv
// Cursor controller bus: enable and raw buttons in, cursor coordinate and move pulse out.
interface matrix_cursor_if;
    logic       en;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [2:0] mdl;
    logic [2:0] mdc;
    logic       moved;

    modport master (
        output en, btn_up, btn_down, btn_left, btn_right,
        input  mdl, mdc, moved
    );

    modport slave (
        input  en, btn_up, btn_down, btn_left, btn_right,
        output mdl, mdc, moved
    );
endinterface

// File: rtl/matrix_cursor_ctrl.sv
// 5x7 matrix cursor: synchronise, debounce and edge-detect four buttons, move with wrap and auto-repeat.
//   state  | meaning
//   IDLE   | waiting for a fresh press
//   DELAY  | first move done, holding until the repeat delay expires
//   REPEAT | auto-repeating every RPT_PERIOD cycles while held
module matrix_cursor_ctrl #(
    parameter int DB_CYCLES  = 250000,
    parameter int DB_W       = 18,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 10000000,
    parameter int RPT_W      = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    matrix_cursor_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [DB_W-1:0]  DB_TC    = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_TC = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TC   = RPT_W'(RPT_PERIOD - 1);

    logic [3:0]            btn_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            db_q, db_d, db_prev_q;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]            press;

    state_t                state_q, state_d;
    logic [1:0]            dir_q, dir_d;
    logic [RPT_W-1:0]      rpt_cnt_q, rpt_cnt_d;
    logic                  do_move;
    logic [1:0]            move_dir;

    logic [2:0]            mdl_q, mdl_d, mdc_q, mdc_d;
    logic                  moved_q, moved_d;

    // Bit index doubles as the direction code.
    assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign press   = db_q & ~db_prev_q;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_TC) db_d[i] = sync2_q[i];
                else                      db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            rpt_cnt_q <= '0;
            mdl_q     <= '0;
            mdc_q     <= '0;
            moved_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            rpt_cnt_q <= rpt_cnt_d;
            mdl_q     <= mdl_d;
            mdc_q     <= mdc_d;
            moved_q   <= moved_d;
        end
    end

    // Release is checked before terminal count so a release never yields a move.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rpt_cnt_d = rpt_cnt_q + 1'b1;
        do_move   = 1'b0;
        move_dir  = dir_q;
        if (!bus.en) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rpt_cnt_d = '0;
                    if (|press) begin
                        if      (press[0]) move_dir = DIR_UP;
                        else if (press[1]) move_dir = DIR_DOWN;
                        else if (press[2]) move_dir = DIR_LEFT;
                        else               move_dir = DIR_RIGHT;
                        do_move = 1'b1;
                        dir_d   = move_dir;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (!db_q[dir_q]) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DELAY_TC) begin
                        do_move   = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = REPEAT;
                    end
                end
                REPEAT: begin
                    if (!db_q[dir_q]) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == PER_TC) begin
                        do_move   = 1'b1;
                        rpt_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    // Wrap compares use >= so an out-of-range value can never persist.
    always_comb begin
        mdl_d   = mdl_q;
        mdc_d   = mdc_q;
        moved_d = do_move;
        if (do_move) begin
            case (move_dir)
                DIR_UP:    mdl_d = (mdl_q == 3'd0 || mdl_q > 3'd6) ? 3'd6 : mdl_q - 3'd1;
                DIR_DOWN:  mdl_d = (mdl_q >= 3'd6) ? 3'd0 : mdl_q + 3'd1;
                DIR_LEFT:  mdc_d = (mdc_q == 3'd0 || mdc_q > 3'd4) ? 3'd4 : mdc_q - 3'd1;
                default:   mdc_d = (mdc_q >= 3'd4) ? 3'd0 : mdc_q + 3'd1;
            endcase
        end
    end

    assign bus.mdl   = mdl_q;
    assign bus.mdc   = mdc_q;
    assign bus.moved = moved_q;

endmodule
